// File: rtl/log2_approx_pkg.sv
// log2_approx_pkg: shared constants and parameter helpers for the log2/ln pipeline
package log2_approx_pkg;
  localparam logic [15:0] LN2_Q16 = 16'hB172;
  function automatic int int_off(input int data_w, input int frac_w);
    return data_w - 1 - frac_w;
  endfunction
  function automatic bit params_ok(input int data_w, input int frac_w, input int out_w, input int out_frac_w);
    return (out_frac_w <= data_w - 1) && (out_w - out_frac_w >= $clog2(data_w) + 1) && (frac_w < data_w);
  endfunction
endpackage

// File: rtl/log2_approx_pipe_lzc_prio.sv
// lzc_prio: priority leading-zero counter with zero flag
module lzc_prio #(
  parameter int DATA_W = 16,
  localparam int CW = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] x,
  output logic [CW-1:0]     cnt,
  output logic              zero
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DATA_W; i++) if (x[i]) cnt = CW'(DATA_W - 1 - i);
  end
  assign zero = ~|x;
endmodule

// File: rtl/log2_approx_pipe.sv
// log2_approx_pipe: four-stage multi-lane fixed-point log2/ln approximation with valid/ready stall
module log2_approx_pipe
  import log2_approx_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 10,
  parameter int OUT_W      = 16,
  parameter int OUT_FRAC_W = 10,
  parameter int LANES      = 1,
  parameter int BYP_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_mode,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [BYP_W-1:0]          in_bypass,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_W-1:0]    out_log,
  output logic [LANES-1:0]          out_zero,
  output logic [BYP_W-1:0]          out_bypass
);
  localparam int CW = $clog2(DATA_W);
  localparam int IW = OUT_W - OUT_FRAC_W;
  localparam int PW = OUT_W + 17;
  localparam int IOFF = int_off(DATA_W, FRAC_W);
  localparam logic [OUT_W-1:0] MIN = {1'b1, {(OUT_W-1){1'b0}}};
  if (!params_ok(DATA_W, FRAC_W, OUT_W, OUT_FRAC_W)) begin : g_bad
    $error("log2_approx_pipe: illegal parameter set");
  end
  logic adv;
  logic v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic m0_q, m0_d, m1_q, m1_d, m2_q, m2_d;
  logic [BYP_W-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
  logic [LANES-1:0][DATA_W-1:0] d0_q, d0_d, x1_q, x1_d, sh_w;
  logic [LANES-1:0][CW-1:0] l1_q, l1_d, lzc_w;
  logic [LANES-1:0] z1_q, z1_d, z2_q, z2_d, z3_q, z3_d, zero_w;
  logic [LANES-1:0][OUT_W-1:0] g2_q, g2_d, o3_q, o3_d, log_w, res_w;
  logic [LANES-1:0][PW-1:0] prod_w;
  logic unused_ok;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lzc_prio #(.DATA_W(DATA_W)) u_lzc (.x(d0_q[i]), .cnt(lzc_w[i]), .zero(zero_w[i]));
  end
  assign adv = !v3_q || out_ready;
  assign in_ready = adv;
  always_comb begin
    sh_w = '0;
    prod_w = '0;
    log_w = '0;
    res_w = '0;
    for (int i = 0; i < LANES; i++) begin
      sh_w[i] = x1_q[i] << l1_q[i];
      log_w[i] = {IW'(IOFF - int'(l1_q[i])), sh_w[i][DATA_W-2 -: OUT_FRAC_W]};
      prod_w[i] = {{(PW-OUT_W){g2_q[i][OUT_W-1]}}, g2_q[i]} * PW'(LN2_Q16);
      res_w[i] = z2_q[i] ? MIN : m2_q ? prod_w[i][OUT_W+15:16] : g2_q[i];
    end
  end
  assign unused_ok = ^{sh_w, prod_w};
  always_comb begin
    v0_d = adv ? in_valid : v0_q;
    m0_d = adv ? in_mode : m0_q;
    d0_d = adv ? in_data : d0_q;
    b0_d = adv ? in_bypass : b0_q;
    v1_d = adv ? v0_q : v1_q;
    m1_d = adv ? m0_q : m1_q;
    x1_d = adv ? d0_q : x1_q;
    l1_d = adv ? lzc_w : l1_q;
    z1_d = adv ? zero_w : z1_q;
    b1_d = adv ? b0_q : b1_q;
    v2_d = adv ? v1_q : v2_q;
    m2_d = adv ? m1_q : m2_q;
    g2_d = adv ? log_w : g2_q;
    z2_d = adv ? z1_q : z2_q;
    b2_d = adv ? b1_q : b2_q;
    v3_d = adv ? v2_q : v3_q;
    o3_d = adv ? res_w : o3_q;
    z3_d = adv ? z2_q : z3_q;
    b3_d = adv ? b2_q : b3_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0; m0_q <= 1'b0; d0_q <= '0; b0_q <= '0;
      v1_q <= 1'b0; m1_q <= 1'b0; x1_q <= '0; l1_q <= '0; z1_q <= '0; b1_q <= '0;
      v2_q <= 1'b0; m2_q <= 1'b0; g2_q <= '0; z2_q <= '0; b2_q <= '0;
      v3_q <= 1'b0; o3_q <= '0; z3_q <= '0; b3_q <= '0;
    end else begin
      v0_q <= v0_d; m0_q <= m0_d; d0_q <= d0_d; b0_q <= b0_d;
      v1_q <= v1_d; m1_q <= m1_d; x1_q <= x1_d; l1_q <= l1_d; z1_q <= z1_d; b1_q <= b1_d;
      v2_q <= v2_d; m2_q <= m2_d; g2_q <= g2_d; z2_q <= z2_d; b2_q <= b2_d;
      v3_q <= v3_d; o3_q <= o3_d; z3_q <= z3_d; b3_q <= b3_d;
    end
  end
  assign out_valid = v3_q;
  assign out_log = o3_q;
  assign out_zero = z3_q;
  assign out_bypass = b3_q;
endmodule

// File: tb/tb_log2_approx_pipe.sv
// tb_log2_approx_pipe: directed self-checking bench for single-lane and four-lane configurations
module tb_log2_approx_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_mode, out_ready, in_ready, out_valid, out_zero;
  logic [15:0] in_data, out_log;
  logic [31:0] in_bypass, out_bypass;
  logic in4_valid, in4_mode, out4_ready, in4_ready, out4_valid;
  logic [63:0] in4_data, out4_log;
  logic [31:0] in4_bypass, out4_bypass;
  logic [3:0] out4_zero;
  int tests = 0;
  int fails = 0;
  log2_approx_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_bypass(in_bypass), .out_valid(out_valid), .out_ready(out_ready),
    .out_log(out_log), .out_zero(out_zero), .out_bypass(out_bypass)
  );
  log2_approx_pipe #(.LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in4_valid), .in_ready(in4_ready), .in_mode(in4_mode),
    .in_data(in4_data), .in_bypass(in4_bypass), .out_valid(out4_valid), .out_ready(out4_ready),
    .out_log(out4_log), .out_zero(out4_zero), .out_bypass(out4_bypass)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  bit          vm [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 1};
  logic [15:0] vd [12] = '{16'h0400, 16'h0800, 16'h0600, 16'h0001, 16'hFFFF, 16'h0800,
                           16'h0001, 16'h0400, 16'hFFFF, 16'h0600, 16'h0000, 16'h0000};
  logic [15:0] ve [12] = '{16'h0000, 16'h0400, 16'h0200, 16'hD800, 16'h17FF, 16'h02C5,
                           16'hE446, 16'h0000, 16'h10A1, 16'h0162, 16'h8000, 16'h8000};
  bit          vz [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
  logic [15:0] bd [8] = '{16'h0400, 16'h0800, 16'h0600, 16'h0001, 16'hFFFF, 16'h0000, 16'h0C00, 16'h0002};
  logic [15:0] be [8] = '{16'h0000, 16'h0400, 16'h0200, 16'hD800, 16'h17FF, 16'h8000, 16'h0600, 16'hDC00};
  bit          pat [16] = '{1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 1, 1, 1};
  initial begin
    #100000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
  initial begin
    int sent, rcv, cyc;
    bit stall;
    logic [15:0] hl;
    logic [31:0] hb;
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_bypass = '0; out_ready = 1'b0;
    in4_valid = 1'b0; in4_mode = 1'b0; in4_data = 64'h0001_0000_0800_0400; in4_bypass = 32'hDEADBEEF;
    out4_ready = 1'b1;
    step;
    step;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_log", out_log, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_bypass", out_bypass, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst4_in_ready", in4_ready, 1);
    chk("rst4_out_valid", out4_valid, 0);
    out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      in_valid = (n < 12);
      if (n < 12) begin
        in_mode = vm[n];
        in_data = vd[n];
        in_bypass = 32'h1000 + n;
      end
      in4_valid = (n == 0);
      chk("stream_in_ready", in_ready, 1);
      if (n == 3) chk("latency_not_early", out_valid, 0);
      if (n >= 4) begin
        chk($sformatf("stream_valid_%0d", n - 4), out_valid, 1);
        chk($sformatf("stream_log_%0d", n - 4), out_log, ve[n-4]);
        chk($sformatf("stream_zero_%0d", n - 4), out_zero, vz[n-4]);
        chk($sformatf("stream_byp_%0d", n - 4), out_bypass, 32'h1000 + n - 4);
      end
      if (n == 4) begin
        chk("lane4_valid", out4_valid, 1);
        chk("lane4_log", out4_log, 64'hD800_8000_0400_0000);
        chk("lane4_zero", out4_zero, 4'b0100);
        chk("lane4_byp", out4_bypass, 32'hDEADBEEF);
      end
      if (n == 5) chk("lane4_single", out4_valid, 0);
      step;
    end
    chk("stream_drained", out_valid, 0);
    sent = 0; rcv = 0; cyc = 0; stall = 0; hl = '0; hb = '0;
    in_mode = 1'b0;
    while (rcv < 8 && cyc < 200) begin
      out_ready = pat[cyc % 16];
      in_valid = (sent < 8);
      in_data = bd[sent % 8];
      in_bypass = 32'h200 + sent;
      #1;
      if (stall) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_log", out_log, hl);
        chk("bp_hold_byp", out_bypass, hb);
      end
      chk("bp_in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        chk($sformatf("bp_log_%0d", rcv), out_log, be[rcv]);
        chk($sformatf("bp_byp_%0d", rcv), out_bypass, 32'h200 + rcv);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      stall = out_valid && !out_ready;
      hl = out_log;
      hb = out_bypass;
      cyc++;
      step;
    end
    chk("bp_count", rcv, 8);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) step;
    chk("bp_no_dup", out_valid, 0);
    for (int n = 0; n < 4; n++) begin
      in_valid = 1'b1;
      in_mode = 1'b0;
      in_data = (n == 0) ? 16'h0000 : 16'h0800;
      in_bypass = 32'h300 + n;
      step;
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_log", out_log, 16'h8000);
    chk("pre_rst_zero", out_zero, 1);
    chk("pre_rst_byp", out_bypass, 32'h300);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_log", out_log, 0);
    chk("mid_rst_zero", out_zero, 0);
    chk("mid_rst_byp", out_bypass, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    for (int n = 0; n < 6; n++) begin
      step;
      chk("no_stale", out_valid, 0);
    end
    in_valid = 1'b1;
    in_data = 16'h0800;
    in_bypass = 32'h3AA;
    for (int n = 1; n <= 4; n++) begin
      step;
      in_valid = 1'b0;
      if (n < 4) chk("post_rst_early", out_valid, 0);
    end
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_log", out_log, 16'h0400);
    chk("post_rst_byp", out_bypass, 32'h3AA);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/log2_approx_pipe.md
Name: log2_approx_pipe

Overview:
Parametrised, multi-lane successor to the Q6.10 log2 approximation stage. Per lane: leading-zero count, then assembly of a signed fixed-point log2 as integer part plus mantissa bits. A per-transaction mode additionally scales the result to natural log.
Adds valid/ready backpressure, an explicit zero-input flag and a payload bypass of configurable width.
Sits ahead of the softmax/division datapath in place of the fixed single-lane stage.

Parameters:
DATA_W, 16, unsigned input width per lane
FRAC_W, 10, fraction bits of input (input is UQ(DATA_W-FRAC_W).FRAC_W)
OUT_W, 16, signed output width per lane
OUT_FRAC_W, 10, fraction bits of output; requires OUT_FRAC_W <= DATA_W-1 and OUT_W-OUT_FRAC_W >= clog2(DATA_W)+1
LANES, 1, number of parallel lanes sharing one handshake
BYP_W, 32, width of sideband payload carried alongside, unmodified

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  block accepts input this cycle
in_mode  in  1  0 = log2, 1 = ln
in_data  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
in_bypass  in  BYP_W  sideband payload
out_valid  out  1  output transaction valid
out_ready  in  1  downstream accepts
out_log  out  LANES*OUT_W  signed result per lane
out_zero  out  LANES  lane input was zero
out_bypass  out  BYP_W  payload delayed with its transaction

Behaviour:
- Four register stages, S0..S3. Latency is 4 cycles from accept (in_valid & in_ready) to out_valid when out_ready is held high. Throughput is 1 per cycle.
- Global stall: adv = !v3 | out_ready. All stages load only when adv. in_ready = adv, purely combinational from v3 and out_ready.
- Bubbles are not collapsed. Stage valids v0..v3 shift as a whole on adv.
- While stalled (out_valid=1, out_ready=0), out_* hold stable.
- S0: register data, mode, bypass and valid.
- S1: per lane, lzc = number of leading zeros (0..DATA_W-1); zero = (x == 0).
- S2: integer part = (DATA_W-1-FRAC_W) - lzc, sign-extended to OUT_W-OUT_FRAC_W bits.
  - Fraction = bits [DATA_W-2 -: OUT_FRAC_W] of (x << lzc), truncated.
  - log2 = {int, frac}.
- S3, mode 0: out_log = log2.
- S3, mode 1: out_log = (log2 * LN2_Q16) >>> 16, where LN2_Q16 = 16'hB172. Signed multiply; arithmetic shift (floor); result truncated to OUT_W.
- Zero lane: out_zero=1 and out_log = most negative value (1 followed by zeros), in both modes; no scaling applied.
- Reset: all valids cleared and all data registers zeroed. Outputs are out_valid=0, out_log=0, out_zero=0, out_bypass=0. in_ready=1 on the first cycle after reset.
- Reset mid-operation: in-flight transactions are discarded and never emitted.
- Simultaneous accept and output with out_ready=1: both occur, with no bubble inserted.
- Data and bypass are ignored when the corresponding valid is 0; the registers still load on adv.
- Inputs are treated as unsigned; the MSB is magnitude, not sign.

Decomposition:
- Package log2_approx_pkg holds:
  - LN2_Q16 constant
  - function computing the integer offset DATA_W-1-FRAC_W
  - parameter-legality checks (elaboration assertions)
- Sub-module lzc_prio: parametrised DATA_W priority leading-zero counter. Outputs count (clog2(DATA_W) bits) and zero flag. Instantiated once per lane in a generate loop.
- Handshake and stage valid chain live in the top module only.

Test Plan:
- Defaults, mode 0, out_ready=1. in_data = 0x0400, 0x0800, 0x0600, 0x0001, 0xFFFF -> out_log = 0x0000, 0x0400, 0x0200, 0xD800, 0x17FF, each 4 cycles after accept. Back-to-back inputs give back-to-back outputs.
- Mode 1. in_data = 0x0800 -> 0x02C5; in_data = 0x0001 -> 0xE446; in_data = 0x0400 -> 0x0000.
- Zero input, both modes. in_data = 0x0000 -> out_log = 0x8000, out_zero = 1; nonzero inputs give out_zero = 0.
- LANES=4, lanes = {0x0001, 0x0000, 0x0800, 0x0400} (lane 3..0) -> out_log = {0xD800, 0x8000, 0x0400, 0x0000}, out_zero = 4'b0100. Bypass 0xDEADBEEF is emitted with its transaction.
- Backpressure: stream 8 transactions with out_ready toggling randomly and 3 low cycles in a row.
  - in_ready drops exactly when out_valid & !out_ready.
  - Outputs hold stable while stalled.
  - All 8 results arrive in order; no loss or duplication.
- Reset with 3 transactions in flight: rst high for 1 cycle -> out_valid = 0 and out_log/out_zero/out_bypass = 0 the next cycle. No stale output ever appears; a new transaction after reset has latency 4.
